// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC, issues instruction-memory requests, holds the
// fetched word while decode stalls and applies redirects from next-PC logic.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [31:0] pc4_out,
   output logic        misalign_err
);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e      state_q;
   logic [31:0] fetch_pc_q;
   logic        pend_q;
   logic [31:0] pend_tgt_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        valid_q;
   logic        misalign_q;

   logic        redir_ok;
   logic        redir_bad;
   logic        pend_now;
   logic [31:0] pend_tgt_now;

   always_comb begin
      redir_ok     = redir_valid && (redir_target[1:0] == 2'b00);
      redir_bad    = redir_valid && (redir_target[1:0] != 2'b00);
      // A redirect arriving in the same cycle as the response counts as
      // pending already, so that response is discarded too.
      pend_now     = pend_q || redir_ok;
      pend_tgt_now = redir_ok ? redir_target : pend_tgt_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         instr_q    <= '0;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= redir_bad;
         unique case (state_q)
            StIdle: begin
               if (redir_ok) begin
                  fetch_pc_q <= redir_target;
               end
               state_q <= StReq;
            end
            StReq: begin
               if (imem_ready) begin
                  if (pend_now) begin
                     fetch_pc_q <= pend_tgt_now;
                     pend_q     <= 1'b0;
                  end else begin
                     instr_q <= imem_rdata;
                     pc_q    <= fetch_pc_q;
                     valid_q <= 1'b1;
                     state_q <= StHold;
                  end
               end else if (redir_ok) begin
                  // Outstanding request must complete first; last redirect wins.
                  pend_q     <= 1'b1;
                  pend_tgt_q <= redir_target;
               end
            end
            StHold: begin
               if (redir_ok) begin
                  fetch_pc_q <= redir_target;
                  valid_q    <= 1'b0;
                  state_q    <= StReq;
               end else if (!stall) begin
                  fetch_pc_q <= pc_q + 32'd4;
                  valid_q    <= 1'b0;
                  state_q    <= StReq;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      imem_req     = (state_q == StReq);
      imem_addr    = fetch_pc_q;
      instr_valid  = valid_q;
      instr        = instr_q;
      pc_out       = pc_q;
      pc4_out      = pc_q + 32'd4;
      misalign_err = misalign_q;
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vector table, a hand-written
// wait/stall sequence, then randomized traffic against a reference model.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset, stall, redir_valid, imem_ready;
   logic [31:0] redir_target, imem_rdata;
   logic        imem_req, instr_valid, misalign_err;
   logic [31:0] imem_addr, instr, pc_out, pc4_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redir_valid (redir_valid),
      .redir_target(redir_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .pc_out      (pc_out),
      .pc4_out     (pc4_out),
      .misalign_err(misalign_err)
   );

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rv;
      logic [31:0] rt;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_mis;
   } vec_t;

   vec_t vecs[20];

   // Reference model: fetch is either idle, waiting on memory, or holding a word.
   int          m_phase;  // 0 idle, 1 waiting, 2 holding
   logic [31:0] m_fetch, m_instr, m_pc;
   logic        m_mis;
   logic [31:0] m_pend[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic s, input logic rv, input logic [31:0] rt,
                        input logic rdy, input logic [31:0] rd);
      reset = r; stall = s; redir_valid = rv; redir_target = rt;
      imem_ready = rdy; imem_rdata = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input bit chk_instr,
                             input logic e_mis);
      chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) chk({tag, ".imem_addr"}, imem_addr, e_addr);
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
      chk({tag, ".pc_out"}, pc_out, e_pc);
      chk({tag, ".pc4_out"}, pc4_out, e_pc + 32'd4);
      if (chk_instr) chk({tag, ".instr"}, instr, e_instr);
      chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e_mis});
   endtask

   task automatic model_step(input logic r, input logic s, input logic rv,
                             input logic [31:0] rt, input logic rdy, input logic [31:0] rd);
      logic ok;
      ok = rv && (rt % 4 == 0);
      if (!r) begin
         m_phase = 0; m_fetch = RST_PC; m_pend.delete();
         m_instr = '0; m_pc = RST_PC; m_mis = 1'b0;
         return;
      end
      m_mis = rv && (rt % 4 != 0);
      case (m_phase)
         0: begin
            if (ok) m_fetch = rt;
            m_phase = 1;
         end
         1: begin
            if (ok) begin
               m_pend.delete();
               m_pend.push_back(rt);
            end
            if (rdy) begin
               if (m_pend.size() > 0) m_fetch = m_pend.pop_front();
               else begin
                  m_instr = rd; m_pc = m_fetch; m_phase = 2;
               end
            end
         end
         default: begin
            if (ok) begin
               m_fetch = rt; m_phase = 1;
            end else if (!s) begin
               m_fetch = m_pc + 4; m_phase = 1;
            end
         end
      endcase
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
      imem_ready = 1'b0; imem_rdata = '0;

      //            rst  stl  rv   rt            rdy  rdata         req  addr          vld  pc            instr         mis
      vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h3000,     1'b0,32'h3000,     32'h0,        1'b0};
      vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h3000,     1'b0,32'h3000,     32'h0,        1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h3000,     1'b0,32'h3000,     32'h0,        1'b0};
      vecs[3]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3000,     1'b0,32'h3000,     32'h0,        1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hA000_0001,1'b0,32'h3000,     1'b1,32'h3000,     32'hA000_0001,1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3004,     1'b0,32'h3000,     32'h0,        1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hA000_0002,1'b0,32'h3004,     1'b1,32'h3004,     32'hA000_0002,1'b0};
      vecs[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3008,     1'b0,32'h3004,     32'h0,        1'b0};
      vecs[8]  = '{1'b1,1'b0,1'b1,32'h3100,     1'b0,32'h0,        1'b1,32'h3008,     1'b0,32'h3004,     32'h0,        1'b0};
      vecs[9]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hBAD0_BAD0,1'b1,32'h3100,     1'b0,32'h3004,     32'h0,        1'b0};
      vecs[10] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hB000_0001,1'b0,32'h3100,     1'b1,32'h3100,     32'hB000_0001,1'b0};
      vecs[11] = '{1'b1,1'b1,1'b1,32'h3200,     1'b0,32'h0,        1'b1,32'h3200,     1'b0,32'h3100,     32'h0,        1'b0};
      vecs[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hC000_0001,1'b0,32'h3200,     1'b1,32'h3200,     32'hC000_0001,1'b0};
      vecs[13] = '{1'b1,1'b1,1'b1,32'h3102,     1'b0,32'h0,        1'b0,32'h3200,     1'b1,32'h3200,     32'hC000_0001,1'b1};
      vecs[14] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h3200,     1'b1,32'h3200,     32'hC000_0001,1'b0};
      vecs[15] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,32'h3200,     32'h0,        1'b0};
      vecs[16] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hD000_0001,1'b0,32'hFFFF_FFFC,1'b1,32'hFFFF_FFFC,32'hD000_0001,1'b0};
      vecs[17] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,32'hFFFF_FFFC,32'h0,        1'b0};
      vecs[18] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hE000_0001,1'b0,32'h3000,     1'b0,32'h3000,     32'h0,        1'b0};
      vecs[19] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hF000_0001,1'b1,32'h3000,     1'b0,32'h3000,     32'h0,        1'b0};

      for (int i = 0; i < 20; i++) begin
         apply(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rt, vecs[i].rdy, vecs[i].rdata);
         check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid || !vecs[i].rst,
                    vecs[i].e_mis);
      end

      // Memory waits three cycles, then decode stalls four cycles on the held word.
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h5555_5555);
         check_outs($sformatf("wait%0d", i), 1'b1, 32'h3000, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0);
      end
      apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      check_outs("resp", 1'b0, 32'h3000, 1'b1, 32'h3000, 32'h1234_5678, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h9999_9999);
         check_outs($sformatf("stall%0d", i), 1'b0, 32'h3000, 1'b1, 32'h3000, 32'h1234_5678,
                    1'b1, 1'b0);
      end
      apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_outs("resume", 1'b1, 32'h3004, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0);

      // Randomized traffic against the reference model, starting from reset.
      for (int c = 0; c < 3000; c++) begin
         logic r, s, rv, rdy;
         logic [31:0] rt, rd;
         r   = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
         s   = ($urandom_range(0, 9) < 4);
         rv  = ($urandom_range(0, 9) == 0);
         rt  = $urandom;
         if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) rt[31:2] = 30'h3FFF_FFFF;
         rdy = ($urandom_range(0, 1) == 1);
         rd  = $urandom;
         model_step(r, s, rv, rt, rdy, rd);
         apply(r, s, rv, rt, rdy, rd);
         check_outs($sformatf("rnd%0d", c), (m_phase == 1), m_fetch, (m_phase == 2), m_pc,
                    m_instr, (m_phase == 2), m_mis);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
